// File: rtl/irq_dispatcher_pkg.sv
// Shared definitions for the interrupt dispatcher: state encodings,
// parameter defaults and the vector address helper.
package irq_dispatcher_pkg;

    localparam int          NUM_IRQ_DEF    = 4;
    localparam int          ID_W_DEF       = 2;
    localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0100;
    localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0010;
    localparam int          HOLDOFF_DEF    = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PEND    = 3'd1,
        SERVICE = 3'd2,
        CLEAR   = 3'd3,
        HOLD    = 3'd4
    } state_t;

    // Handler address, 32-bit arithmetic wrapping mod 2^32.
    function automatic logic [31:0] vec_addr(
        input logic [31:0] id,
        input logic [31:0] base,
        input logic [31:0] stride
    );
        return base + id * stride;
    endfunction

endpackage

// File: rtl/irq_dispatcher_id_decoder.sv
// ID to one-hot decoder, the inverse of the priority encoder.
// Ports: en (gate), id (encoded ID), onehot (decoded line, 0 when en=0).
module irq_id_decoder #(
    parameter int NUM_IRQ = 4,
    parameter int ID_W    = 2
) (
    input  logic               en,
    input  logic [ID_W-1:0]    id,
    output logic [NUM_IRQ-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[id] = 1'b1;
        end
    end

endmodule

// File: rtl/irq_dispatcher.sv
// CPU-side interrupt handshake: request, ack, end-of-interrupt, clear.
// Ports: clk/rst, irq_valid/irq_id from the encoder, global_en/mask,
// cpu_intr/cpu_vector/cpu_ack/cpu_eoi to the core, irq_clr and
// in_service back to the sources, busy and spurious_cnt status.
module irq_dispatcher
    import irq_dispatcher_pkg::*;
#(
    parameter int          NUM_IRQ    = NUM_IRQ_DEF,
    parameter int          ID_W       = ID_W_DEF,
    parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
    parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF,
    parameter int          HOLDOFF    = HOLDOFF_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               irq_valid,
    input  logic [ID_W-1:0]    irq_id,
    input  logic               global_en,
    input  logic [NUM_IRQ-1:0] mask,
    output logic               cpu_intr,
    output logic [31:0]        cpu_vector,
    input  logic               cpu_ack,
    input  logic               cpu_eoi,
    output logic [NUM_IRQ-1:0] irq_clr,
    output logic [NUM_IRQ-1:0] in_service,
    output logic               busy,
    output logic [7:0]         spurious_cnt
);

    localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;

    state_t             state, state_n;
    logic [ID_W-1:0]    id_q, id_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic               spur_inc;
    logic               accept;
    logic               dec_en;
    logic [NUM_IRQ-1:0] dec_oh;

    assign accept = irq_valid & global_en & ~mask[irq_id];

    always_comb begin
        state_n  = state;
        id_n     = id_q;
        cnt_n    = cnt_q;
        spur_inc = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = PEND;
                    id_n    = irq_id;
                end
            end
            PEND: begin
                // Ack beats a simultaneous withdraw; eoi is not looked at.
                if (cpu_ack) begin
                    state_n = SERVICE;
                end else if (mask[id_q] | ~global_en) begin
                    state_n  = IDLE;
                    spur_inc = 1'b1;
                end
            end
            SERVICE: begin
                if (cpu_eoi) begin
                    state_n = CLEAR;
                end
            end
            CLEAR: begin
                state_n = HOLD;
                cnt_n   = CNT_W'(HOLDOFF - 1);
            end
            HOLD: begin
                // Leave on the cycle the counter steps down to zero, so the
                // next sample lands HOLDOFF cycles after the clear pulse.
                if (cnt_q <= CNT_W'(1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign dec_en = (state_n == SERVICE) | (state_n == CLEAR);

    irq_id_decoder #(
        .NUM_IRQ (NUM_IRQ),
        .ID_W    (ID_W)
    ) u_dec (
        .en     (dec_en),
        .id     (id_n),
        .onehot (dec_oh)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            id_q  <= '0;
            cnt_q <= '0;
        end else begin
            state <= state_n;
            id_q  <= id_n;
            cnt_q <= cnt_n;
        end
    end

    // Outputs are registered from the next-state view so they line up
    // with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_intr   <= 1'b0;
            cpu_vector <= '0;
            irq_clr    <= '0;
            in_service <= '0;
            busy       <= 1'b0;
        end else begin
            cpu_intr   <= (state_n == PEND);
            cpu_vector <= (state_n == PEND)
                        ? vec_addr(32'(id_n), VEC_BASE, VEC_STRIDE)
                        : '0;
            irq_clr    <= (state_n == CLEAR) ? dec_oh : '0;
            in_service <= (state_n == SERVICE) ? dec_oh : '0;
            busy       <= (state_n != IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spurious_cnt <= '0;
        end else if (spur_inc && spurious_cnt != 8'hFF) begin
            spurious_cnt <= spurious_cnt + 8'd1;
        end
    end

endmodule
